// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction ROM port, redirect/stall controls and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline and ROM.
interface instr_fetch_unit_if #(
   parameter int IMEM_AW = 8
);
   logic               imem_req;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               stall;
   logic               PCSrc;
   logic [31:0]        branch_target;
   logic               Jump;
   logic [31:0]        jump_target;
   logic [31:0]        inst;
   logic [31:0]        pc_plus4;
   logic               inst_valid;

   modport master (
      output imem_req, imem_addr, inst, pc_plus4, inst_valid,
      input  imem_rdata, stall, PCSrc, branch_target, Jump, jump_target
   );

   modport slave (
      input  imem_req, imem_addr, inst, pc_plus4, inst_valid,
      output imem_rdata, stall, PCSrc, branch_target, Jump, jump_target
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, synchronous-ROM request and IF/ID register; request to IF/ID is two edges.
// Stall freezes PC and IF/ID and parks the one in-flight word; a redirect squashes everything in flight.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_unit_if.master fif
);
   typedef enum logic {RUN, HELD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_inc;
   logic        pend;
   logic [31:0] pend_pc4;
   logic [31:0] hold_buf;
   logic [31:0] hold_pc4;
   logic [31:0] inst_q;
   logic [31:0] pc4_q;
   logic        vld_q;
   logic        req;
   logic        redir;
   logic [31:0] redir_tgt;
   logic        unused_bits;

   assign req       = !reset && !fif.stall;
   assign redir     = fif.Jump | fif.PCSrc;
   // Jump wins over a simultaneous taken branch; targets are always word aligned.
   assign redir_tgt = fif.Jump ? {fif.jump_target[31:2], 2'b00}
                               : {fif.branch_target[31:2], 2'b00};
   assign pc_inc    = pc + 32'd4;

   assign fif.imem_req   = req;
   assign fif.imem_addr  = pc[IMEM_AW+1:2];
   assign fif.inst       = inst_q;
   assign fif.pc_plus4   = pc4_q;
   assign fif.inst_valid = vld_q;

   assign unused_bits = ^{fif.jump_target[1:0], fif.branch_target[1:0],
                          pc[1:0], pc[31:IMEM_AW+2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pc       <= RESET_PC;
         pend     <= 1'b0;
         pend_pc4 <= 32'd0;
         hold_buf <= 32'd0;
         hold_pc4 <= 32'd0;
         inst_q   <= 32'd0;
         pc4_q    <= 32'd0;
         vld_q    <= 1'b0;
      end else if (redir) begin
         // The request issued this cycle, any word in flight and any parked word are dropped.
         state  <= RUN;
         pc     <= redir_tgt;
         pend   <= 1'b0;
         inst_q <= 32'd0;
         vld_q  <= 1'b0;
      end else if (!fif.stall) begin
         pc       <= pc_inc;
         pend     <= 1'b1;
         pend_pc4 <= pc_inc;
         case (state)
            HELD: begin
               inst_q <= hold_buf;
               pc4_q  <= hold_pc4;
               vld_q  <= 1'b1;
               state  <= RUN;
            end
            default: begin
               if (pend) begin
                  inst_q <= fif.imem_rdata;
                  pc4_q  <= pend_pc4;
                  vld_q  <= 1'b1;
               end else begin
                  inst_q <= 32'd0;
                  vld_q  <= 1'b0;
               end
            end
         endcase
      end else begin
         // No request goes out while stalled, so at most one word ever needs parking.
         pend <= 1'b0;
         if (pend) begin
            hold_buf <= fif.imem_rdata;
            hold_pc4 <= pend_pc4;
            state    <= HELD;
         end
      end
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the single-cycle `Controller`. It owns the program counter and issues word reads to a synchronous instruction ROM. It registers the returned word into an IF/ID output (`inst`, `pc_plus4`, `inst_valid`) that drives the controller's `Op`/`Funct` fields and the register-file decode. It accepts branch (`PCSrc`) and jump (`Jump`) redirects and a downstream stall, and buffers any ROM data in flight while stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, 8: ROM word-address width. ROM depth is 2^IMEM_AW words.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  ROM read strobe.
- `imem_addr`  out  IMEM_AW  ROM word address, equal to `pc[IMEM_AW+1:2]`.
- `imem_rdata`  in  32  ROM data, valid exactly one cycle after an `imem_req` cycle.
- `stall`  in  1  downstream hold. IF/ID outputs and PC freeze.
- `PCSrc`  in  1  taken-branch redirect.
- `branch_target`  in  32  branch destination.
- `Jump`  in  1  jump redirect.
- `jump_target`  in  32  jump destination, already formed as {pc_plus4[31:28], instr_index, 2'b00}.
- `inst`  out  32  registered instruction to the controller/decode.
- `pc_plus4`  out  32  registered PC+4 of `inst`.
- `inst_valid`  out  1  `inst` is a real fetched instruction; 0 means a bubble (nop).

## Operation
- Internal state:
  - `pc`: next fetch address.
  - `pend` / `pend_pc4`: a request is in flight and its PC+4.
  - `hold_buf` / `hold_vld`: data captured while stalled.
  - IF/ID registers.
- The stall FSM has two states, `RUN` and `HELD`. `HELD` is equivalent to `hold_vld` = 1.
- `imem_req` = !reset & !stall. `imem_addr` is combinational from `pc`.
- Redirect: `redir` = `Jump` | `PCSrc`.
  - If both are asserted, `Jump` wins and the target is `jump_target`. Otherwise it is `branch_target`.
  - Target bits [1:0] are forced to 00.
- Cycle with `redir` = 1, which has priority over `stall`:
  - `pc` <= target.
  - `pend` <= 0, so the request issued this cycle is squashed.
  - `hold_vld` <= 0.
  - `inst` <= 0, `inst_valid` <= 0.
  - `pc_plus4` holds.
- Cycle with `redir` = 0 and `stall` = 0:
  - If a request is issued: `pc` <= pc+4, `pend` <= 1, `pend_pc4` <= pc+4.
  - If `hold_vld` = 1:
    - IF/ID <= {`hold_buf`, its pc4, 1}.
    - `hold_vld` <= 0.
    - State returns to `RUN`.
  - Otherwise, if `pend` = 1: IF/ID <= {`imem_rdata`, `pend_pc4`, 1}.
  - Otherwise: `inst_valid` <= 0 and `inst` <= 0.
- Cycle with `redir` = 0 and `stall` = 1:
  - `pc` holds and IF/ID holds.
  - No request is issued, so `pend` <= 0.
  - If `pend` = 1, `hold_buf` <= `imem_rdata` and `hold_vld` <= 1 (`RUN`→`HELD`).
  - At most one word is ever buffered, because no request is issued while stalled.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- ROM addressing wraps: only `pc[IMEM_AW+1:2]` is presented.

## Timing
- Reset, applied in any cycle including mid-stall or mid-redirect:
  - `pc` = `RESET_PC`.
  - `inst` = 0, `pc_plus4` = 0, `inst_valid` = 0.
  - `pend` = 0, `hold_vld` = 0.
  - `imem_req` = 0 during reset.
- First request goes out in the first cycle with `reset` low.
- Fetch latency: request in cycle n → `inst` valid after the edge ending cycle n+1. There are 2 edges from request to IF/ID.
- Steady state: one instruction per cycle, `pc_plus4` increasing by 4.
- Redirect asserted in cycle n:
  - Bubble appears in IF/ID after edge n.
  - Request to the target goes out in n+1, if not stalled.
  - Target instruction is valid after edge n+2.
- Stall in cycles n..m:
  - IF/ID is frozen through edge m.
  - On release in cycle m+1, the buffered word, if any, loads at edge m+1 and the next request also goes out in m+1.
  - No instruction is lost or duplicated.
- `stall` and `redir` together: redirect behaviour applies and the buffer is dropped.

## Test plan
- Reset release, ROM[0..3] = 34080005, 3409000A, 01095021, 01285823 → `imem_addr` 0,1,2,3 on consecutive cycles; `inst` shows the same words one cycle later, with `pc_plus4` = 4, 8, C, 10 and `inst_valid` = 1.
- `stall` high for 3 cycles right after 3409000A issues → `inst` holds 34080005; on release `inst` = 3409000A then 01095021; no skips or repeats.
- `PCSrc` = 1, `branch_target` = 0x20, in the cycle `inst` = 114C0002 → next cycle `inst_valid` = 0 and `inst` = 0; `imem_addr` = 8 in the following cycle; `inst` = ROM[8] with `pc_plus4` = 0x24 one cycle later.
- `Jump` = 1, `jump_target` = 0x4, together with `PCSrc` = 1, `branch_target` = 0x40 → fetch resumes at word 1 (3409000A).
- Redirect asserted while `stall` = 1 and `hold_vld` = 1 → the buffered word never appears; the first valid `inst` after release is ROM[target].
- `reset` pulsed mid-stream and mid-stall → all outputs return to their reset values in the next cycle; fetch restarts at `RESET_PC`.
